// File: rtl/mimc_hash_sequencer.sv
`timescale 1ns/1ps
// mimc_hash_sequencer: frames a valid/ready element stream into messages for a MiMC
// Feistel sponge core, resetting the core between messages and returning one digest each.
module mimc_hash_sequencer #(
    parameter int                N_BITS  = 254,
    parameter logic [N_BITS-1:0] MODULUS = 254'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001),
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N_BITS-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_BITS-1:0] m_data,
    output logic [CNT_W-1:0]  m_len,
    output logic              hash_rst,
    output logic              hash_en,
    output logic [N_BITS-1:0] hash_in,
    input  logic              hash_done,
    input  logic [N_BITS-1:0] hash_out
);

    typedef enum logic [2:0] {
        ST_CORE_RST = 3'd0,
        ST_WARMUP   = 3'd1,
        ST_IDLE     = 3'd2,
        ST_ABSORB   = 3'd3,
        ST_OUTPUT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Inputs are below 2^N_BITS < 2P, so a single conditional subtract is canonical.
    function automatic logic [N_BITS-1:0] reduce_elem(input logic [N_BITS-1:0] d);
        logic [N_BITS-1:0] r;
        if (d >= MODULUS) begin
            r = d - MODULUS;
        end else begin
            r = d;
        end
        return r;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              timer_r;
    logic              timer_nxt_s;
    logic              done_prev_r;
    logic              last_r;
    logic              s_ready_r;
    logic              m_valid_r;
    logic              hash_rst_r;
    logic              hash_en_r;
    logic [N_BITS-1:0] m_data_r;
    logic [N_BITS-1:0] hash_in_r;
    logic [CNT_W-1:0]  m_len_r;
    logic              accept_s;
    logic              done_rise_s;
    logic              capture_s;
    logic              out_hs_s;
    logic              s_ready_nxt_s;
    logic              hash_rst_nxt_s;
    logic              hash_en_nxt_s;

    assign accept_s    = (state_r == ST_IDLE) && s_valid && s_ready_r;
    // done_prev masks a done level left over from the previous block
    assign done_rise_s = hash_done && !done_prev_r;
    assign capture_s   = (state_r == ST_ABSORB) && done_rise_s && last_r;
    assign out_hs_s    = (state_r == ST_OUTPUT) && m_valid_r && m_ready;

    // State register and two-cycle phase timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_CORE_RST;
            timer_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = 1'b0;
        case (state_r)
            ST_CORE_RST: begin
                if (timer_r) begin
                    state_nxt_s = ST_WARMUP;
                end else begin
                    timer_nxt_s = 1'b1;
                end
            end
            ST_WARMUP: begin
                if (timer_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    timer_nxt_s = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ABSORB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ABSORB: begin
                if (done_rise_s) begin
                    state_nxt_s = last_r ? ST_OUTPUT : ST_IDLE;
                end else begin
                    state_nxt_s = ST_ABSORB;
                end
            end
            ST_OUTPUT: begin
                if (out_hs_s) begin
                    state_nxt_s = ST_CORE_RST;
                end else begin
                    state_nxt_s = ST_OUTPUT;
                end
            end
            default: begin
                state_nxt_s = ST_CORE_RST;
            end
        endcase
    end

    // Output decode, registered below so every control output is glitch-free
    always_comb begin
        s_ready_nxt_s  = (state_nxt_s == ST_IDLE);
        hash_rst_nxt_s = (state_nxt_s == ST_CORE_RST);
        hash_en_nxt_s  = accept_s;
    end

    // Registered outputs and per-message bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready_r   <= 1'b0;
            m_valid_r   <= 1'b0;
            m_data_r    <= {N_BITS{1'b0}};
            m_len_r     <= {CNT_W{1'b0}};
            hash_rst_r  <= 1'b1;
            hash_en_r   <= 1'b0;
            hash_in_r   <= {N_BITS{1'b0}};
            last_r      <= 1'b0;
            done_prev_r <= 1'b0;
        end else begin
            s_ready_r   <= s_ready_nxt_s;
            hash_rst_r  <= hash_rst_nxt_s;
            hash_en_r   <= hash_en_nxt_s;
            done_prev_r <= hash_done;
            if (accept_s) begin
                hash_in_r <= reduce_elem(s_data);
                last_r    <= s_last;
                if (m_len_r != CNT_MAX) begin
                    m_len_r <= m_len_r + CNT_ONE;
                end
            end else if (out_hs_s) begin
                m_len_r <= {CNT_W{1'b0}};
            end
            if (capture_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= hash_out;
            end else if (out_hs_s) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    assign s_ready  = s_ready_r;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign m_len    = m_len_r;
    assign hash_rst = hash_rst_r;
    assign hash_en  = hash_en_r;
    assign hash_in  = hash_in_r;

endmodule

// File: tb/tb_mimc_hash_sequencer.sv
`timescale 1ns/1ps
// Bench for mimc_hash_sequencer: a stand-in sponge core with a simple chaining mix,
// directed message vectors and a scoreboard monitor on the digest port.
module tb_mimc_hash_sequencer;

    localparam int N        = 254;
    localparam int CW       = 16;
    localparam int CORE_LAT = 4;
    localparam logic [N-1:0] P = 254'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001);

    typedef struct packed {
        logic [N-1:0]  dig;
        logic [CW-1:0] len;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [N-1:0]  s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  m_data;
    logic [CW-1:0] m_len;
    logic          hash_rst;
    logic          hash_en;
    logic [N-1:0]  hash_in;
    logic          hash_done;
    logic [N-1:0]  hash_out;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   mr_mode;

    always #5 clk = ~clk;

    mimc_hash_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_len    (m_len),
        .hash_rst (hash_rst),
        .hash_en  (hash_en),
        .hash_in  (hash_in),
        .hash_done(hash_done),
        .hash_out (hash_out)
    );

    // Stand-in core chaining step; digest of [x1..xk] folds this from zero.
    function automatic logic [N-1:0] mix(input logic [N-1:0] s, input logic [N-1:0] x);
        return ((s << 1) ^ x) + 254'd3;
    endfunction

    function automatic logic [N-1:0] ref_reduce(input logic [N-1:0] d);
        return (d >= P) ? (d - P) : d;
    endfunction

    function automatic logic [N-1:0] rand_elem();
        logic [255:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return t[N-1:0];
    endfunction

    // Core model: one INIT cycle after reset, then CORE_LAT cycles per block, done held while idle
    logic [N-1:0] core_state;
    logic [N-1:0] core_in;
    logic         core_done;
    logic         core_init;
    int           core_busy;
    assign hash_done = core_done;
    assign hash_out  = core_state;

    always @(posedge clk) begin
        if (hash_rst) begin
            core_state <= '0;
            core_in    <= '0;
            core_done  <= 1'b0;
            core_init  <= 1'b1;
            core_busy  <= 0;
        end else if (core_init) begin
            core_init <= 1'b0;
        end else if (core_busy != 0) begin
            if (core_busy == 1) begin
                core_state <= mix(core_state, core_in);
                core_done  <= 1'b1;
            end
            core_busy <= core_busy - 1;
        end else if (hash_en) begin
            core_in   <= hash_in;
            core_done <= 1'b0;
            core_busy <= CORE_LAT;
        end
    end

    // m_ready driver
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on digest handshake, plus core-protocol checks
    logic          prev_hold;
    logic          prev_en;
    logic [N-1:0]  prev_data;
    logic [CW-1:0] prev_len;
    int            en_pulses;
    int            rst_run;
    int            last_rst_len;
    initial begin
        prev_hold = 1'b0; prev_en = 1'b0; prev_data = '0; prev_len = '0;
        en_pulses = 0; rst_run = 0; last_rst_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_hold) begin
                    n_vec++;
                    if (m_valid !== 1'b1 || m_data !== prev_data || m_len !== prev_len) begin
                        n_fail++;
                        $display("FAIL hold_stable: m_valid=%0b m_data=%0h m_len=%0d, required 1 %0h %0d",
                                 m_valid, m_data, m_len, prev_data, prev_len);
                    end
                end
                if (m_valid && m_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL digest_unexpected: m_data=%0h m_len=%0d, required no digest", m_data, m_len);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (m_data !== mon_e.dig || m_len !== mon_e.len) begin
                            n_fail++;
                            $display("FAIL digest: m_data=%0h m_len=%0d, required %0h %0d",
                                     m_data, m_len, mon_e.dig, mon_e.len);
                        end
                    end
                end
                if (hash_en) begin
                    n_vec++;
                    if (prev_en || core_init || core_busy != 0 || hash_rst) begin
                        n_fail++;
                        $display("FAIL hash_en_pulse: prev_en=%0b core_init=%0b core_busy=%0d, required idle single pulse",
                                 prev_en, core_init, core_busy);
                    end
                end
                if (core_busy != 0) begin
                    n_vec++;
                    if (hash_in !== core_in) begin
                        n_fail++;
                        $display("FAIL hash_in_stable: hash_in=%0h, required %0h", hash_in, core_in);
                    end
                end
            end
            prev_hold = rst && m_valid && !m_ready;
            prev_data = m_data;
            prev_len  = m_len;
            prev_en   = hash_en;
            if (hash_en) en_pulses++;
            if (hash_rst) begin
                rst_run++;
            end else begin
                if (rst_run != 0) last_rst_len = rst_run;
                rst_run = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] dig, input int len);
        exp_t e;
        e.dig = dig;
        e.len = CW'(len);
        exp_q.push_back(e);
    endtask

    // Offer one element; called #1 after a rising edge.
    task automatic send_elem(input logic [N-1:0] d, input logic last, input logic [N-1:0] exp_hin);
        int guard;
        guard = 0;
        s_data = d; s_last = last; s_valid = 1'b1;
        while (s_ready !== 1'b1 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (s_ready !== 1'b1) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: s_ready=%0b, required 1", s_ready);
            s_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            s_valid = 1'b0;
            chk("hash_in", hash_in, exp_hin);
            chk("s_ready_absorb", N'(s_ready), N'(1'b0));
            chk("hash_en_pulse", N'(hash_en), N'(1'b1));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d digests outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        logic [N-1:0] msg [4];
        logic [N-1:0] st;
        int           len;
        int           p0;
        int           guard;
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; mr_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready",  N'(s_ready),  N'(1'b0));
        chk("rst_m_valid",  N'(m_valid),  N'(1'b0));
        chk("rst_m_data",   m_data,       N'(0));
        chk("rst_m_len",    N'(m_len),    N'(0));
        chk("rst_hash_rst", N'(hash_rst), N'(1'b1));
        chk("rst_hash_en",  N'(hash_en),  N'(1'b0));
        chk("rst_hash_in",  hash_in,      N'(0));
        rst = 1'b1;

        // single element [0]
        p0 = en_pulses;
        push_exp(N'(3), 1);
        send_elem(N'(0), 1'b1, N'(0));
        drain();
        chk("pulses_msg1", N'(en_pulses - p0), N'(1));

        // [1,2,3]
        p0 = en_pulses;
        push_exp(N'(28), 3);
        send_elem(N'(1), 1'b0, N'(1));
        send_elem(N'(2), 1'b0, N'(2));
        send_elem(N'(3), 1'b1, N'(3));
        drain();
        chk("pulses_msg3", N'(en_pulses - p0), N'(3));

        // reduction boundaries
        push_exp(N'(8), 1);
        send_elem(P + 254'd5, 1'b1, N'(5));
        push_exp(N'(3), 1);
        send_elem(P, 1'b1, N'(0));
        push_exp(P + 254'd2, 1);
        send_elem(P - 254'd1, 1'b1, P - 254'd1);
        drain();

        // back-to-back [7],[7] with a stalled consumer
        mr_mode = 0;
        push_exp(N'(10), 1);
        send_elem(N'(7), 1'b1, N'(7));
        guard = 0;
        while (m_valid !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("stall_m_valid", N'(m_valid), N'(1'b1));
        repeat (10) @(posedge clk);
        #1;
        mr_mode = 1;
        push_exp(N'(10), 1);
        send_elem(N'(7), 1'b1, N'(7));
        chk("core_rst_len", N'(last_rst_len), N'(2));
        drain();

        // abort during the second absorb of [1,2,3], then [9]
        send_elem(N'(1), 1'b0, N'(1));
        send_elem(N'(2), 1'b0, N'(2));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_hash_rst", N'(hash_rst), N'(1'b1));
        chk("abort_s_ready",  N'(s_ready),  N'(1'b0));
        chk("abort_m_len",    N'(m_len),    N'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(N'(12), 1);
        send_elem(N'(9), 1'b1, N'(9));
        drain();

        // random traffic
        mr_mode = 2;
        for (int m = 0; m < 50; m++) begin
            len = int'($urandom_range(1, 4));
            st = '0;
            for (int i = 0; i < len; i++) begin
                msg[i] = rand_elem();
                if ((m % 7) == 0 && i == 0) msg[i] = P + N'(m);
                st = mix(st, ref_reduce(msg[i]));
            end
            push_exp(st, len);
            for (int i = 0; i < len; i++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    if (s_ready == 1'b0 && $urandom_range(0, 1) == 1) begin
                        s_valid = 1'b1;
                        s_data  = rand_elem();
                        s_last  = 1'($urandom_range(0, 1));
                    end else begin
                        s_valid = 1'b0;
                    end
                    @(posedge clk); #1;
                end
                send_elem(msg[i], (i == len - 1), ref_reduce(msg[i]));
            end
        end
        mr_mode = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
